// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad matrix emulator.
//   state_t    : command sequencer states
//   KEY_*      : bit slices of the 4-bit key index {row[1:0], col[1:0]}
//   COL_IDLE   : column sense value with no contact (active-low, all high)
//   lfsr_next  : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11),
//                right-shifting so bit 0 is the output bit
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_BOUNCE,
    HOLD,
    R_BOUNCE,
    GAP
  } state_t;

  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_bounce_gen.sv
// bounce_gen: contact-bounce pattern generator for one bounce phase.
// Restarted by 'start' on the edge that enters a bounce phase, then runs
// while 'en' is high, producing one contact level per BOUNCE_STEP cycles.
//   clk, reset  : clock, async active-low reset
//   start       : restart the step counter and load the first level
//   en          : phase active (counters advance)
//   press       : 1 for the press phase, 0 for release; this is both the
//                 first level of the alternating pattern and the forced
//                 level of the final step in LFSR mode
//   steps       : number of bounce steps in this phase (non-zero)
//   level       : contact level for the current step
//   step_done   : last cycle of the current step
//   last_step   : current step is the final one of the phase
// Macro KEYPAD_LFSR_BOUNCE_EN: per-step level taken from LFSR bit 0.
module bounce_gen
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_STEP = 64,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       en,
  input  logic       press,
  input  logic [7:0] steps,
  output logic       level,
  output logic       step_done,
  output logic       last_step
);

  localparam int            CW        = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
  localparam logic [CW-1:0] STEP_LAST = CW'(BOUNCE_STEP - 1);

  // An all-zero seed would lock the LFSR at zero forever.
  if (LFSR_SEED == 16'h0000) begin : g_seed_chk
    $error("bounce_gen: LFSR_SEED must be non-zero");
  end

  logic [CW-1:0] cyc_cnt;
  logic [7:0]    step_cnt;

  assign step_done = (cyc_cnt == STEP_LAST);
  assign last_step = (step_cnt == steps - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt  <= '0;
      step_cnt <= '0;
    end else if (start) begin
      cyc_cnt  <= '0;
      step_cnt <= '0;
    end else if (en) begin
      cyc_cnt <= step_done ? '0 : cyc_cnt + CW'(1);
      if (step_done) step_cnt <= step_cnt + 8'd1;
    end
  end

`ifdef KEYPAD_LFSR_BOUNCE_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic        next_last;  // the step about to begin is the final one

  assign lfsr_nxt  = lfsr_next(lfsr);
  assign next_last = (step_cnt == steps - 8'd2);

  // Each step consumes one LFSR value; the state carries over between phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr  <= LFSR_SEED;
      level <= 1'b0;
    end else if (start) begin
      level <= (steps == 8'd1) ? press : lfsr[0];
    end else if (en && step_done) begin
      lfsr  <= lfsr_nxt;
      level <= next_last ? press : lfsr_nxt[0];
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 level <= 1'b0;
    else if (start)             level <= press;
    else if (en && step_done)   level <= ~level;
  end
`endif

endmodule

// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator: responder side of a 4x4 row-select/column-sense
// keypad. A press command (valid/ready) walks press bounce, hold, release
// bounce and a released gap, then pulses done.
//   clk, reset            : clock, async active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_key               : {row[1:0], col[1:0]}
//   cmd_hold              : stable contact cycles (0 treated as 1)
//   cmd_bounce            : bounce steps per edge (0 skips both bounce phases)
//   r_sel                 : active-low row drive from the scanner
//   col                   : active-low column sense, registered
//   key_down              : registered contact state
//   busy, done            : command in progress / one-cycle completion pulse
// Macro KEYPAD_LFSR_BOUNCE_EN: pseudo-random bounce (see bounce_gen).
module keypad_matrix_emulator
  import keypad_pkg::*;
#(
  parameter int          CNT_W       = 24,
  parameter int          BOUNCE_STEP = 64,
  parameter int          GAP_CYCLES  = 1024,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_key,
  input  logic [CNT_W-1:0] cmd_hold,
  input  logic [7:0]       cmd_bounce,
  input  logic [3:0]       r_sel,
  output logic [3:0]       col,
  output logic             key_down,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] hold_last;
  logic [3:0]       key_q;
  logic [CNT_W-1:0] hold_q;
  logic [7:0]       bounce_q;
  logic             ld_cmd;
  logic             contact;
  logic             done_d;
  logic [3:0]       col_d;

  logic       bg_start, bg_en, bg_press;
  logic [7:0] bg_steps;
  logic       bg_level, bg_step_done, bg_last_step;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign hold_last = (hold_q == '0) ? '0 : hold_q - CNT_W'(1);
  assign bg_en     = (state == P_BOUNCE) || (state == R_BOUNCE);
  // At accept the bounce count is not latched yet, so feed it straight through.
  assign bg_steps  = (state == IDLE) ? cmd_bounce : bounce_q;

  bounce_gen #(
    .BOUNCE_STEP (BOUNCE_STEP),
    .LFSR_SEED   (LFSR_SEED)
  ) u_bounce (
    .clk       (clk),
    .reset     (reset),
    .start     (bg_start),
    .en        (bg_en),
    .press     (bg_press),
    .steps     (bg_steps),
    .level     (bg_level),
    .step_done (bg_step_done),
    .last_step (bg_last_step)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    contact  = 1'b0;
    ld_cmd   = 1'b0;
    done_d   = 1'b0;
    bg_start = 1'b0;
    bg_press = 1'b0;
    case (state)
      IDLE: begin
        bg_press = 1'b1;
        if (cmd_valid) begin
          ld_cmd = 1'b1;
          cnt_d  = '0;
          if (cmd_bounce != 8'd0) begin
            state_d  = P_BOUNCE;
            bg_start = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end
      end
      P_BOUNCE: begin
        contact  = bg_level;
        bg_press = 1'b1;
        if (bg_step_done && bg_last_step) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        contact = 1'b1;
        if (cnt == hold_last) begin
          cnt_d = '0;
          if (bounce_q != 8'd0) begin
            state_d  = R_BOUNCE;
            bg_start = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      R_BOUNCE: begin
        contact = bg_level;
        if (bg_step_done && bg_last_step) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the selected key's row bit matters; any other low rows are ignored.
  always_comb begin
    col_d = COL_IDLE;
    if (contact && !r_sel[key_q[KEY_ROW_MSB:KEY_ROW_LSB]])
      col_d[key_q[KEY_COL_MSB:KEY_COL_LSB]] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      key_q    <= '0;
      hold_q   <= '0;
      bounce_q <= '0;
      col      <= COL_IDLE;
      key_down <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      col      <= col_d;
      key_down <= contact;
      done     <= done_d;
      if (ld_cmd) begin
        key_q    <= cmd_key;
        hold_q   <= cmd_hold;
        bounce_q <= cmd_bounce;
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Self-checking bench for keypad_matrix_emulator: table-driven column checks,
// hand sequences for timing corners, and randomized traffic against a
// per-cycle contact-schedule reference model.
module tb_keypad_matrix_emulator;
  localparam int          CW   = 24;
  localparam int          BS   = 64;
  localparam int          GAP  = 100;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_key;
  logic [CW-1:0] cmd_hold;
  logic [7:0]    cmd_bounce;
  logic [3:0]    r_sel;
  logic [3:0]    col;
  logic          key_down, busy, done;

  int checks = 0;
  int errors = 0;
  bit rnd_rsel = 0;

  always #5 clk = ~clk;

  keypad_matrix_emulator #(
    .CNT_W(CW), .BOUNCE_STEP(BS), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .cmd_bounce(cmd_bounce),
    .r_sel(r_sel), .col(col), .key_down(key_down), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A command is expanded into the list of contact values, one per cycle,
  // that it spends outside idle. Each clock pops one; registered outputs
  // show the popped value; the pop that empties the list is the done cycle.
  bit          sched[$];
  logic [3:0]  m_key;
  logic [15:0] m_lfsr;
  logic [3:0]  e_col;
  logic        e_kd, e_done, e_busy;

  task automatic push_n(input bit v, input int n);
    for (int k = 0; k < n; k++) sched.push_back(v);
  endtask

  task automatic build(input logic [CW-1:0] h, input logic [7:0] b);
    bit v;
    for (int s = 0; s < int'(b); s++) begin
`ifdef KEYPAD_LFSR_BOUNCE_EN
      v = (s == int'(b) - 1) ? 1'b1 : m_lfsr[0];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
      v = (s % 2 == 0);
`endif
      push_n(v, BS);
    end
    push_n(1'b1, (h == 0) ? 1 : int'(h));
    for (int s = 0; s < int'(b); s++) begin
`ifdef KEYPAD_LFSR_BOUNCE_EN
      v = (s == int'(b) - 1) ? 1'b0 : m_lfsr[0];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
      v = (s % 2 == 1);
`endif
      push_n(v, BS);
    end
    push_n(1'b0, GAP);
  endtask

  initial begin
    bit c, was_idle;
    e_col = 4'hF; e_kd = 0; e_done = 0; e_busy = 0; m_lfsr = SEED; m_key = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        sched.delete();
        e_col = 4'hF; e_kd = 0; e_done = 0; e_busy = 0; m_lfsr = SEED;
      end else begin
        was_idle = (sched.size() == 0);
        c = 1'b0;
        e_done = 1'b0;
        if (!was_idle) begin
          c = sched.pop_front();
          if (sched.size() == 0) e_done = 1'b1;
        end
        e_kd  = c;
        e_col = 4'hF;
        if (c && !r_sel[m_key[3:2]]) e_col[m_key[1:0]] = 1'b0;
        if (was_idle && cmd_valid) begin
          m_key = cmd_key;
          build(cmd_hold, cmd_bounce);
        end
        e_busy = (sched.size() != 0);
      end
    end
  end

  // per-cycle scoreboard
  initial forever begin
    @(negedge clk);
    check("sb_col", {12'h0, col}, {12'h0, e_col});
    check("sb_key_down", {15'h0, key_down}, {15'h0, e_kd});
    check("sb_done", {15'h0, done}, {15'h0, e_done});
    check("sb_busy", {15'h0, busy}, {15'h0, e_busy});
    check("sb_ready", {15'h0, cmd_ready}, {15'h0, !e_busy});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input int max);
    int n = 0;
    while (!cmd_ready && n < max) begin
      @(negedge clk);
      n++;
      if (rnd_rsel) r_sel = 4'($urandom);
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got 0 expected 1 after %0d cycles", max);
    end
  endtask

  task automatic issue(input logic [3:0] k, input logic [CW-1:0] h, input logic [7:0] b);
    wait_ready(3000);
    cmd_valid = 1; cmd_key = k; cmd_hold = h; cmd_bounce = b;
    @(negedge clk);
    cmd_valid = 0;
    check("accept_busy", {15'h0, busy}, 16'h1);
  endtask

  // Counts samples with col==pat, then samples after the last low one up to
  // and including the done pulse.
  task automatic measure(input logic [3:0] pat, output int n_low, output int n_gap);
    n_low = 0; n_gap = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (col == pat) n_low++;
      else if (n_low > 0) n_gap++;
      if (done) break;
    end
    check("done_seen", {15'h0, done}, 16'h1);
    check("ready_at_done", {15'h0, cmd_ready}, 16'h1);
  endtask

  typedef struct {
    logic [3:0] key;
    logic [3:0] rsel;
    logic [3:0] exp_col;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n_low, n_gap, t, ndone;
`ifdef KEYPAD_LFSR_BOUNCE_EN
    int j0 = 2;
    bit p_exp[3] = '{1'b0, 1'b0, 1'b0};
    bit r_exp[3] = '{1'b1, 1'b1, 1'b1};
`else
    int j0 = 0;
    bit p_exp[3] = '{1'b0, 1'b1, 1'b0};
    bit r_exp[3] = '{1'b1, 1'b0, 1'b1};
`endif
    // key index = {row, col}; col low only when r_sel[row] is low
    tbl[0] = '{4'h6, 4'b1110, 4'b1111};
    tbl[1] = '{4'h6, 4'b1101, 4'b1011};
    tbl[2] = '{4'h6, 4'b1011, 4'b1111};
    tbl[3] = '{4'h6, 4'b0111, 4'b1111};
    tbl[4] = '{4'h6, 4'b1111, 4'b1111};
    tbl[5] = '{4'h0, 4'b1110, 4'b1110};
    tbl[6] = '{4'hF, 4'b0111, 4'b0111};
    tbl[7] = '{4'h9, 4'b0000, 4'b1101};
    tbl[8] = '{4'h5, 4'b0010, 4'b1111};
    tbl[9] = '{4'h3, 4'b1100, 4'b0111};

    reset = 0; cmd_valid = 0; cmd_key = 0; cmd_hold = 0; cmd_bounce = 0; r_sel = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_col", {12'h0, col}, 16'hF);
    check("rst_key_down", {15'h0, key_down}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_ready", {15'h0, cmd_ready}, 16'h1);
    reset = 1;
    @(negedge clk);

    // 1: plain press, no bounce
    r_sel = 4'b1101;
    issue(4'h6, 10, 0);
    measure(4'b1011, n_low, n_gap);
    check("t1_hold_cycles", 16'(n_low), 16'd10);
    check("t1_gap_cycles", 16'(n_gap), 16'(GAP));

    // hold=0 behaves as one cycle
    r_sel = 4'b0111;
    issue(4'hF, 0, 0);
    measure(4'b0111, n_low, n_gap);
    check("hold0_cycles", 16'(n_low), 16'd1);
    check("hold0_gap", 16'(n_gap), 16'(GAP));

    // 2: row/column table
    foreach (tbl[i]) begin
      r_sel = tbl[i].rsel;
      issue(tbl[i].key, 10, 0);
      repeat (5) @(negedge clk);
      check($sformatf("tbl%0d_col", i), {12'h0, col}, {12'h0, tbl[i].exp_col});
      wait_ready(3000);
    end

    // rotating rows during a long hold (scoreboard checks every cycle)
    issue(4'h6, 40, 0);
    for (int i = 0; i < 40; i++) begin
      r_sel = ~(4'b0001 << (i % 4));
      @(negedge clk);
    end
    wait_ready(3000);

    // 3: bounce pattern, key 0 on row 0
    r_sel = 4'b1110;
    issue(4'h0, 20, 3);
    t = 0;
    for (int j = j0; j < 3; j++) begin
      repeat (j * BS + 32 - t) @(negedge clk);
      t = j * BS + 32;
      check($sformatf("t3_press%0d", j), {15'h0, col[0]}, {15'h0, p_exp[j]});
      check($sformatf("t3_press_kd%0d", j), {15'h0, key_down}, {15'h0, !p_exp[j]});
    end
    repeat (3 * BS + 10 - t) @(negedge clk);
    t = 3 * BS + 10;
    check("t3_hold", {12'h0, col}, 16'hE);
    for (int j = j0; j < 3; j++) begin
      repeat (3 * BS + 20 + j * BS + 32 - t) @(negedge clk);
      t = 3 * BS + 20 + j * BS + 32;
      check($sformatf("t3_rel%0d", j), {15'h0, col[0]}, {15'h0, r_exp[j]});
      check($sformatf("t3_rel_kd%0d", j), {15'h0, key_down}, {15'h0, !r_exp[j]});
    end
    wait_ready(3000);

    // 4: command during HOLD is ignored until after done
    r_sel = 4'b1101;
    issue(4'h6, 30, 0);
    repeat (10) @(negedge clk);
    cmd_valid = 1; cmd_key = 4'hF; cmd_hold = 5; cmd_bounce = 0;
    @(negedge clk);
    check("t4_not_ready", {15'h0, cmd_ready}, 16'h0);
    check("t4_col_unchanged", {12'h0, col}, 16'hB);
    for (int i = 0; i < 500 && !done; i++) @(negedge clk);
    check("t4_done", {15'h0, done}, 16'h1);
    @(negedge clk);
    cmd_valid = 0;
    check("t4_accept_after_done", {15'h0, busy}, 16'h1);
    wait_ready(3000);

    // 5: asynchronous reset mid-HOLD
    issue(4'h6, 50, 0);
    repeat (10) @(negedge clk);
    #2 reset = 0;
    #1;
    check("t5_col", {12'h0, col}, 16'hF);
    check("t5_busy", {15'h0, busy}, 16'h0);
    check("t5_key_down", {15'h0, key_down}, 16'h0);
    check("t5_ready", {15'h0, cmd_ready}, 16'h1);
    repeat (3) @(negedge clk);
    reset = 1;
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t5_no_done", 16'(ndone), 16'd0);
    issue(4'h6, 5, 0);
    wait_ready(3000);

    // randomized traffic
    rnd_rsel = 1;
    for (int i = 0; i < 8000; i++) begin
      r_sel      = 4'($urandom);
      cmd_valid  = ($urandom_range(0, 7) == 0);
      cmd_key    = 4'($urandom);
      cmd_hold   = CW'($urandom_range(0, 30));
      cmd_bounce = 8'($urandom_range(0, 3));
      @(negedge clk);
    end
    cmd_valid = 0;
    wait_ready(3000);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
